// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE (grant) -> EXEC (drive ALU, capture) -> RESP (hold until consumed).
module alu_arbiter #(
  parameter int FIRST_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_sel0,
  input  logic [3:0]  req_sel1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_res,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_ovf,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // "Last served" starts as the other requester so FIRST_PRIO wins the first tie.
  localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gnt_valid_s;
  logic        gnt_idx_s;
  logic        owner_rdy_s;

  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel != 4'd0) && (sel <= 4'd9);
  endfunction

  // Round-robin grant decision, only meaningful in IDLE outside reset.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      if (req_valid0 && req_valid1) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = ~last_q;
      end else if (req_valid0) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = 1'b0;
      end else if (req_valid1) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
      end
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  assign owner_rdy_s = owner_q ? rsp_ready1 : rsp_ready0;

  // Next-state and datapath capture for the three-state sequence.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          owner_d = gnt_idx_s;
          a_d     = gnt_idx_s ? req_a1 : req_a0;
          b_d     = gnt_idx_s ? req_b1 : req_b0;
          sel_d   = gnt_idx_s ? req_sel1 : req_sel0;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Illegal op codes never expose whatever the ALU produced.
        if (sel_legal(sel_q)) begin
          res_d = alu_res;
          ovf_d = alu_ovf;
          err_d = 1'b0;
        end else begin
          res_d = 32'd0;
          ovf_d = 1'b0;
          err_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_rdy_s) begin
          last_d  = owner_q;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= LAST_RST;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sel_q   <= 4'd0;
      res_q   <= 32'd0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready0 = gnt_valid_s && !gnt_idx_s;
  assign req_ready1 = gnt_valid_s && gnt_idx_s;

  assign rsp_valid0 = (state_q == ST_RESP) && !owner_q;
  assign rsp_valid1 = (state_q == ST_RESP) && owner_q;
  assign rsp_res    = res_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_err    = err_q;

  assign alu_a   = (state_q == ST_EXEC) ? a_q : 32'd0;
  assign alu_b   = (state_q == ST_EXEC) ? b_q : 32'd0;
  assign alu_sel = (state_q == ST_EXEC) ? sel_q : 4'd0;

  assign busy     = (state_q != ST_IDLE);
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus
// hand-written round-robin, backpressure and mid-operation reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [1:0]  rrdy;
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic [3:0]  sv [2];
  wire  [1:0]  rdy;
  wire  [1:0]  rv;
  wire  [31:0] rsp_res;
  wire         rsp_ovf;
  wire         rsp_err;
  wire  [31:0] alu_a;
  wire  [31:0] alu_b;
  wire  [3:0]  alu_sel;
  logic [31:0] m_res;
  logic        m_ovf;
  wire         busy;
  wire  [15:0] op_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIRST_PRIO(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid0 (vld[0]),
    .req_valid1 (vld[1]),
    .req_ready0 (rdy[0]),
    .req_ready1 (rdy[1]),
    .req_a0     (av[0]),
    .req_a1     (av[1]),
    .req_b0     (bv[0]),
    .req_b1     (bv[1]),
    .req_sel0   (sv[0]),
    .req_sel1   (sv[1]),
    .rsp_valid0 (rv[0]),
    .rsp_valid1 (rv[1]),
    .rsp_ready0 (rrdy[0]),
    .rsp_ready1 (rrdy[1]),
    .rsp_res    (rsp_res),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_res    (m_res),
    .alu_ovf    (m_ovf),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Shared ALU model; unknown op codes return garbage so error forcing is visible.
  always_comb begin
    m_res = 32'hDEADBEEF;
    m_ovf = 1'b1;
    case (alu_sel)
      4'd1: begin
        m_res = alu_a + alu_b;
        m_ovf = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      4'd2: begin
        m_res = alu_a - alu_b;
        m_ovf = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      4'd3: begin m_res = alu_a ^ alu_b; m_ovf = 1'b0; end
      4'd4: begin m_res = alu_a & alu_b; m_ovf = 1'b0; end
      4'd5: begin m_res = alu_a | alu_b; m_ovf = 1'b0; end
      4'd6: begin m_res = alu_a << alu_b[4:0]; m_ovf = 1'b0; end
      4'd7: begin m_res = alu_a >> alu_b[4:0]; m_ovf = 1'b0; end
      4'd8: begin m_res = $signed(alu_a) >>> alu_b[4:0]; m_ovf = 1'b0; end
      4'd9: begin m_res = {31'd0, ($signed(alu_a) < $signed(alu_b))}; m_ovf = 1'b0; end
      default: begin m_res = 32'hDEADBEEF; m_ovf = 1'b1; end
    endcase
  end

  typedef struct {
    logic        who;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] res;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    vld  = 2'b00;
    rrdy = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [1:0] oh;
    int n;

    vecs[0]  = '{1'b0, 32'd5,          32'd7,          4'd1,  32'd12,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h7FFFFFFF,   32'd1,          4'd1,  32'h80000000,   1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'd10,         32'd3,          4'd2,  32'd7,          1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'd1,          4'd2,  32'h7FFFFFFF,   1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'hF0F0F0F0,   32'hFF00FF00,   4'd3,  32'h0FF00FF0,   1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hF0F0F0F0,   32'hFF00FF00,   4'd4,  32'hF000F000,   1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000000F,   32'h000000F0,   4'd5,  32'h000000FF,   1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'd1,          32'd4,          4'd6,  32'h00000010,   1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h80000000,   32'd4,          4'd7,  32'h08000000,   1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h80000000,   32'd4,          4'd8,  32'hF8000000,   1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'd3,          32'd4,          4'd0,  32'd0,          1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'd0,          4'd9,  32'd1,          1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'd3,          32'd4,          4'd15, 32'd0,          1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'd5,          32'hFFFFFFFE,   4'd9,  32'd0,          1'b0, 1'b0};

    for (int i = 0; i < 2; i++) begin
      av[i] = 32'd0;
      bv[i] = 32'd0;
      sv[i] = 4'd0;
    end

    // Reset with both requesters pushing: no grant may leak through.
    rst  = 1'b1;
    vld  = 2'b11;
    rrdy = 2'b00;
    @(negedge clk);
    chk("rst_no_ready", 32'(rdy), 32'd0);
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rv), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_rsp_flags", {30'd0, rsp_ovf, rsp_err}, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);

    // Vector table: single-requester transactions.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      oh = vecs[i].who ? 2'b10 : 2'b01;
      av[vecs[i].who] = vecs[i].a;
      bv[vecs[i].who] = vecs[i].b;
      sv[vecs[i].who] = vecs[i].sel;
      vld  = oh;
      rrdy = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", i), 32'(rdy), 32'(oh));
      chk($sformatf("v%0d_alu_idle", i), alu_a | alu_b | 32'(alu_sel), 32'd0);
      @(posedge clk);
      #1 vld = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_exec_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d_alu_sel", i), 32'(alu_sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d_exec_no_rsp", i), 32'(rv), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rv), 32'(oh));
      chk($sformatf("v%0d_rsp_res", i), rsp_res, vecs[i].res);
      chk($sformatf("v%0d_rsp_ovf", i), 32'(rsp_ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_alu_resp", i), alu_a | 32'(alu_sel), 32'd0);
      rrdy = oh;
      @(posedge clk);
      #1 rrdy = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_op_count", i), 32'(op_count), 32'(i + 1));
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end

    // Round-robin with both requesters valid and both consumers always ready.
    do_reset();
    av[0] = 32'd100; bv[0] = 32'd1; sv[0] = 4'd1;
    av[1] = 32'd200; bv[1] = 32'd2; sv[1] = 4'd2;
    vld  = 2'b11;
    rrdy = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (rdy == 2'b00 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rr%0d_grant", k), 32'(rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_rsp_valid", k), 32'(rv), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_rsp_res", k), rsp_res, (k % 2 == 0) ? 32'd101 : 32'd198);
      @(negedge clk);
    end
    chk("rr_op_count", 32'(op_count), 32'd4);
    vld  = 2'b00;
    rrdy = 2'b00;

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    av[0] = 32'd1; bv[0] = 32'd2; sv[0] = 4'd1;
    av[1] = 32'd9; bv[1] = 32'd4; sv[1] = 4'd2;
    vld = 2'b01;
    @(negedge clk);
    chk("bp_grant0", 32'(rdy), 32'd1);
    @(posedge clk);
    #1 vld = 2'b10;
    @(negedge clk);
    chk("bp_exec_no_ready", 32'(rdy), 32'd0);
    @(posedge clk);
    #1 rrdy = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_rsp_valid", c), 32'(rv), 32'd1);
      chk($sformatf("bp%0d_rsp_res", c), rsp_res, 32'd3);
      chk($sformatf("bp%0d_no_ready", c), 32'(rdy), 32'd0);
      @(posedge clk);
    end
    #1 rrdy = 2'b01;
    @(negedge clk);
    chk("bp_hold_valid", 32'(rv), 32'd1);
    @(posedge clk);
    #1 rrdy = 2'b00;
    @(negedge clk);
    chk("bp_grant1", 32'(rdy), 32'd2);
    chk("bp_count1", 32'(op_count), 32'd1);
    @(posedge clk);
    #1 vld = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rsp1_valid", 32'(rv), 32'd2);
    chk("bp_rsp1_res", rsp_res, 32'd5);
    rrdy = 2'b10;
    @(posedge clk);
    #1 rrdy = 2'b00;
    @(negedge clk);
    chk("bp_count2", 32'(op_count), 32'd2);

    // Reset asserted while requester 0 is in EXEC drops the operation.
    do_reset();
    av[0] = 32'd5; bv[0] = 32'd7; sv[0] = 4'd1;
    vld = 2'b01;
    @(negedge clk);
    chk("rx_grant0", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    vld = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("rx_in_exec", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rx_idle", 32'(busy), 32'd0);
    chk("rx_op_count", 32'(op_count), 32'd0);
    chk("rx_rsp_res", rsp_res, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rx%0d_no_rsp", c), 32'(rv), 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIO, default 0, index (0/1) of requester holding priority after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid0/req_valid1  input  1  requester n presents an operation.
REQ-005 SHALL have ports req_ready0/req_ready1  output  1  operation of requester n accepted this cycle.
REQ-006 SHALL have ports req_a0/req_a1, req_b0/req_b1  input  32  signed operands of requester n.
REQ-007 SHALL have ports req_sel0/req_sel1  input  4  ALU op code of requester n (1 add, 2 sub, 3 xor, 4 and, 5 or, 6-8 shifts, 9 slt).
REQ-008 SHALL have ports rsp_valid0/rsp_valid1  output  1  result for requester n available.
REQ-009 SHALL have ports rsp_ready0/rsp_ready1  input  1  requester n consumes result.
REQ-010 SHALL have ports rsp_res  output  32  result, rsp_ovf  output  1  overflow, rsp_err  output  1  illegal op code; all shared, valid only with a rsp_valid.
REQ-011 SHALL have ports alu_a, alu_b  output  32, alu_sel  output  4  drive to shared combinational ALU.
REQ-012 SHALL have ports alu_res  input  32, alu_ovf  input  1  combinational ALU outputs.
REQ-013 SHALL have ports busy  output  1  (state != IDLE), op_count  output  16  completed operations.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid, SHALL grant one requester, assert its req_ready combinationally that cycle, capture its a/b/sel and owner index, go to EXEC; otherwise stay.
REQ-016 Arbitration SHALL be round-robin: single request always granted; simultaneous requests granted to the requester not served last (after reset: FIRST_PRIO).
REQ-017 At most one req_ready SHALL be high per cycle, and only in IDLE.
REQ-018 EXEC (exactly one cycle): alu_a/alu_b/alu_sel SHALL drive captured values; on the edge, alu_res/alu_ovf SHALL be registered into rsp_res/rsp_ovf; go to RESP.
REQ-019 Captured sel of 0 or 10-15 SHALL set rsp_err=1 and force rsp_res=0, rsp_ovf=0 regardless of ALU outputs; legal sel SHALL give rsp_err=0.
REQ-020 Outside EXEC, alu_a, alu_b, alu_sel SHALL be 0.
REQ-021 RESP: rsp_valid of owner only SHALL be 1; rsp_res/ovf/err SHALL hold stable until handshake.
REQ-022 RESP with owner's rsp_ready=1: SHALL return to IDLE next cycle, record owner as last served, increment op_count; rsp_ready of non-owner SHALL be ignored.
REQ-023 op_count SHALL saturate at 0xFFFF (no wrap).
REQ-024 Latency: accept at edge T -> rsp_valid high from cycle T+2; back-to-back accepts no closer than 3 cycles (accept, EXEC, RESP with immediate ready).
REQ-025 Requests arriving in EXEC/RESP SHALL see req_ready=0 and wait; req_valid changes while not accepted SHALL have no effect.

Reset
REQ-026 On rst=1 at an edge: state IDLE, rsp_valid0/1=0, rsp_res=0, rsp_ovf=0, rsp_err=0, op_count=0, last served = 1-FIRST_PRIO, captured regs=0.
REQ-027 rst SHALL take precedence over all other inputs; reset in EXEC or RESP SHALL drop the transaction with no response and no op_count increment.
REQ-028 During reset cycle outputs req_ready0/1 SHALL be 0.

Verification
REQ-029 Req0 only: a=5, b=7, sel=1, rsp_ready0=1 -> req_ready0 at T, rsp_valid0 at T+2, rsp_res=12, ovf=0, op_count=1.
REQ-030 Req1 only: a=0x7FFFFFFF, b=1, sel=1 -> rsp_res=0x80000000, rsp_ovf=1, rsp_valid1 only.
REQ-031 Both valid continuously after reset (FIRST_PRIO=0), rsp_ready held 1 -> grants 0,1,0,1; each result on matching rsp_valid; op_count=4 after four.
REQ-032 Req0 sel=0 (a=3, b=4) -> rsp_err=1, rsp_res=0, rsp_ovf=0; then sel=9, a=-1, b=0 -> rsp_res=1, err=0.
REQ-033 Backpressure: rsp_ready0=0 for 5 cycles in RESP while req_valid1=1 -> rsp_valid0 and rsp_res stable, req_ready1=0; ready asserted -> req1 granted next IDLE cycle.
REQ-034 rst=1 during EXEC of req0 -> next cycle IDLE, no rsp_valid, op_count unchanged (0).
